// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor elevator car controller: call latching, SCAN direction choice, timed door sequence
module elevator_ctrl_n #(
    parameter int NUM_FLOORS       = 4,
    parameter int FLOOR_W          = $clog2(NUM_FLOORS),
    parameter int DOOR_OPEN_CYCLES = 10,
    parameter int TIMER_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_req,
    input  logic [NUM_FLOORS-1:0] cab_req,
    input  logic                  door_open_req,
    input  logic                  door_close_req,
    input  logic                  at_floor,
    input  logic [FLOOR_W-1:0]    floor_sensor,
    output logic                  cmd_door_open,
    output logic                  cmd_door_close,
    output logic                  cmd_car_up,
    output logic                  cmd_car_down,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);

    typedef enum logic [2:0] {
        IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_HOLD, DOOR_CLOSE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  cmd_open_q, cmd_close_q, cmd_up_q, cmd_down_q;

    logic above, below, sensor_call, cur_call, sensor_ok, door_is_open;

    always_comb begin
        above       = 1'b0;
        below       = 1'b0;
        sensor_call = 1'b0;
        cur_call    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i > int'(cur_floor_q)))  above       = 1'b1;
            if (pending_q[i] && (i < int'(cur_floor_q)))  below       = 1'b1;
            if (pending_q[i] && (i == int'(floor_sensor))) sensor_call = 1'b1;
            if (pending_q[i] && (i == int'(cur_floor_q)))  cur_call    = 1'b1;
        end
    end

    // Sensor values beyond the last landing are treated as "not at a floor".
    assign sensor_ok    = at_floor && (int'(floor_sensor) < NUM_FLOORS);
    assign door_is_open = (state_q == DOOR_OPEN) || (state_q == DOOR_HOLD);

    always_comb begin
        state_d     = state_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        cur_floor_d = sensor_ok ? floor_sensor : cur_floor_q;
        pending_d   = pending_q | hall_req | cab_req;
        // A call for the landing whose door is open is served, not latched.
        if (door_is_open) pending_d[cur_floor_q] = 1'b0;

        case (state_q)
            IDLE: begin
                if (door_open_req || cur_call) begin
                    state_d = DOOR_OPEN;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (sensor_ok && (sensor_call || (int'(floor_sensor) == NUM_FLOORS - 1)))
                    state_d = DOOR_OPEN;
            end
            MOVE_DOWN: begin
                if (sensor_ok && (sensor_call || (floor_sensor == '0)))
                    state_d = DOOR_OPEN;
            end
            DOOR_OPEN: begin
                if (!door_open_req) begin
                    state_d = DOOR_HOLD;
                    timer_d = TIMER_W'(DOOR_OPEN_CYCLES);
                end
            end
            DOOR_HOLD: begin
                if (door_open_req)
                    state_d = DOOR_OPEN;
                else if (door_close_req || (timer_q == TIMER_W'(1)))
                    state_d = DOOR_CLOSE;
                else
                    timer_d = timer_q - TIMER_W'(1);
            end
            DOOR_CLOSE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            timer_q     <= '0;
            cmd_open_q  <= 1'b0;
            cmd_close_q <= 1'b1;
            cmd_up_q    <= 1'b0;
            cmd_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            timer_q     <= timer_d;
            cmd_open_q  <= (state_d == DOOR_OPEN) || (state_d == DOOR_HOLD);
            cmd_close_q <= (state_d == IDLE) || (state_d == DOOR_CLOSE);
            cmd_up_q    <= (state_d == MOVE_UP);
            cmd_down_q  <= (state_d == MOVE_DOWN);
        end
    end

    assign cmd_door_open  = cmd_open_q;
    assign cmd_door_close = cmd_close_q;
    assign cmd_car_up     = cmd_up_q;
    assign cmd_car_down   = cmd_down_q;
    assign cur_floor      = cur_floor_q;
    assign pending        = pending_q;
    assign dir_up         = dir_up_q;

endmodule
